// File: rtl/pattern_detection_multi.sv
// Multi-channel DSP pattern detector: per-channel masked compare against inter_P,
// with registered/combinational detect, PAST flags, hit counters and overflow/underflow.

module pattern_detection_channel #(
    parameter int WIDTH       = 48,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rstp,
    input  logic                   cep,
    input  logic                   preg,
    input  logic                   stat_clear,
    input  logic [WIDTH-1:0]       inter_p,
    input  logic [WIDTH-1:0]       pat,
    input  logic [WIDTH-1:0]       mask,
    output logic                   detect,
    output logic                   bdetect,
    output logic                   detect_past,
    output logic                   bdetect_past,
    output logic [COUNT_WIDTH-1:0] hit_count
);
    logic det_c, bdet_c, det_q, bdet_q;

    // mask bit 1 marks a don't-care position
    assign det_c  = &(~(inter_p ^ pat) | mask);
    assign bdet_c = &((inter_p ^ pat) | mask);

    assign detect  = preg ? det_q  : det_c;
    assign bdetect = preg ? bdet_q : bdet_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q        <= 1'b0;
            bdet_q       <= 1'b0;
            detect_past  <= 1'b0;
            bdetect_past <= 1'b0;
            hit_count    <= '0;
        end else begin
            if (rstp) begin
                det_q  <= 1'b0;
                bdet_q <= 1'b0;
            end else if (cep) begin
                det_q  <= det_c;
                bdet_q <= bdet_c;
            end

            // PAST follows the visible outputs every clock, independent of CEP
            if (rstp) begin
                detect_past  <= 1'b0;
                bdetect_past <= 1'b0;
            end else begin
                detect_past  <= detect;
                bdetect_past <= bdetect;
            end

            if (rstp || stat_clear)
                hit_count <= '0;
            else if (cep && detect && (hit_count != '1))
                hit_count <= hit_count + COUNT_WIDTH'(1);
        end
    end
endmodule

module pattern_detection_multi #(
    parameter int WIDTH        = 48,
    parameter int NUM_PATTERNS = 2,
    parameter int COUNT_WIDTH  = 8,
    parameter int IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                                clk,
    input  logic                                RST,
    input  logic                                RSTP,
    input  logic                                CEP,
    input  logic [WIDTH-1:0]                    C_reg,
    input  logic [WIDTH-1:0]                    inter_P,
    input  logic                                stat_clear,
    input  logic                                configuration_input,
    input  logic                                configuration_enable,
    output logic                                configuration_output,
    output logic [NUM_PATTERNS-1:0]             PATTERNDETECT,
    output logic [NUM_PATTERNS-1:0]             PATTERNBDETECT,
    output logic [NUM_PATTERNS-1:0]             PATTERNDETECTPAST,
    output logic [NUM_PATTERNS-1:0]             PATTERNBDETECTPAST,
    output logic                                Overflow,
    output logic                                Underflow,
    output logic                                OVF_STICKY,
    output logic                                UNF_STICKY,
    output logic                                MATCH_ANY,
    output logic [IDX_W-1:0]                    MATCH_INDEX,
    output logic [NUM_PATTERNS*COUNT_WIDTH-1:0] HIT_COUNT
);
    localparam int L = 2*WIDTH*NUM_PATTERNS + 4;

    logic [L-1:0] cfg;
    logic         preg, sel_pattern;
    logic [1:0]   sel_mask;
    logic [NUM_PATTERNS-1:0][WIDTH-1:0]       pat, mask;
    logic [NUM_PATTERNS-1:0][COUNT_WIDTH-1:0] hits;

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            cfg <= '0;
        else if (configuration_enable)
            cfg <= {cfg[L-2:0], configuration_input};
    end

    assign configuration_output = cfg[L-1];
    assign preg        = cfg[0];
    assign sel_mask    = cfg[2:1];
    assign sel_pattern = cfg[3];

    always_comb begin
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            pat[k]  = cfg[4 + 2*k*WIDTH +: WIDTH];
            mask[k] = cfg[4 + 2*k*WIDTH + WIDTH +: WIDTH];
        end
        // only channel 0 can take its pattern/mask from C_reg
        if (sel_pattern)
            pat[0] = C_reg;
        case (sel_mask)
            2'b01:   mask[0] = C_reg;
            2'b10:   mask[0] = {~C_reg[WIDTH-2:0], 1'b0};
            2'b11:   mask[0] = {~C_reg[WIDTH-3:0], 2'b00};
            default: mask[0] = cfg[4 + WIDTH +: WIDTH];
        endcase
    end

    for (genvar k = 0; k < NUM_PATTERNS; k++) begin : g_ch
        pattern_detection_channel #(
            .WIDTH       (WIDTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (RST),
            .rstp         (RSTP),
            .cep          (CEP),
            .preg         (preg),
            .stat_clear   (stat_clear),
            .inter_p      (inter_P),
            .pat          (pat[k]),
            .mask         (mask[k]),
            .detect       (PATTERNDETECT[k]),
            .bdetect      (PATTERNBDETECT[k]),
            .detect_past  (PATTERNDETECTPAST[k]),
            .bdetect_past (PATTERNBDETECTPAST[k]),
            .hit_count    (hits[k])
        );
    end

    assign HIT_COUNT = hits;
    assign MATCH_ANY = |PATTERNDETECT;

    always_comb begin
        MATCH_INDEX = '0;
        for (int k = NUM_PATTERNS-1; k >= 0; k--)
            if (PATTERNDETECT[k])
                MATCH_INDEX = IDX_W'(k);
    end

    // result left the pattern window without landing on the inverse pattern
    assign Overflow  = PATTERNDETECTPAST[0]  & ~PATTERNDETECT[0] & ~PATTERNBDETECT[0];
    assign Underflow = PATTERNBDETECTPAST[0] & ~PATTERNDETECT[0] & ~PATTERNBDETECT[0];

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            OVF_STICKY <= 1'b0;
            UNF_STICKY <= 1'b0;
        end else if (RSTP || stat_clear) begin
            OVF_STICKY <= 1'b0;
            UNF_STICKY <= 1'b0;
        end else begin
            if (Overflow)  OVF_STICKY <= 1'b1;
            if (Underflow) UNF_STICKY <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pattern_detection_multi.sv
// Directed bench for pattern_detection_multi at WIDTH=8, NUM_PATTERNS=2.

module tb_pattern_detection_multi;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int CW = 8;
    localparam int L  = 2*W*N + 4;

    logic          clk = 1'b0;
    logic          RST, RSTP, CEP, stat_clear;
    logic [W-1:0]  C_reg, inter_P;
    logic          configuration_input, configuration_enable, configuration_output;
    logic [N-1:0]  PATTERNDETECT, PATTERNBDETECT, PATTERNDETECTPAST, PATTERNBDETECTPAST;
    logic          Overflow, Underflow, OVF_STICKY, UNF_STICKY, MATCH_ANY;
    logic [0:0]    MATCH_INDEX;
    logic [N*CW-1:0] HIT_COUNT;

    int checks = 0;
    int failures = 0;

    pattern_detection_multi #(.WIDTH(W), .NUM_PATTERNS(N), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .RST(RST), .RSTP(RSTP), .CEP(CEP), .C_reg(C_reg), .inter_P(inter_P),
        .stat_clear(stat_clear), .configuration_input(configuration_input),
        .configuration_enable(configuration_enable), .configuration_output(configuration_output),
        .PATTERNDETECT(PATTERNDETECT), .PATTERNBDETECT(PATTERNBDETECT),
        .PATTERNDETECTPAST(PATTERNDETECTPAST), .PATTERNBDETECTPAST(PATTERNBDETECTPAST),
        .Overflow(Overflow), .Underflow(Underflow), .OVF_STICKY(OVF_STICKY),
        .UNF_STICKY(UNF_STICKY), .MATCH_ANY(MATCH_ANY), .MATCH_INDEX(MATCH_INDEX),
        .HIT_COUNT(HIT_COUNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p;
        logic [N-1:0] det;
        logic [N-1:0] bdet;
        logic         any;
        logic         idx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] mk_cfg(input logic [W-1:0] p0, m0, p1, m1,
                                            input logic selp, input logic [1:0] selm,
                                            input logic preg);
        return {m1, p1, m0, p0, selp, selm, preg};
    endfunction

    // first bit shifted lands at the top of the chain
    task automatic load_cfg(input logic [L-1:0] w);
        for (int i = L-1; i >= 0; i--) begin
            configuration_enable = 1'b1;
            configuration_input  = w[i];
            step();
        end
        configuration_enable = 1'b0;
        configuration_input  = 1'b0;
    endtask

    vec_t vecs[5];
    logic [2*L-1:0] bits;
    logic [L-1:0] base_cfg;

    initial begin
        // P0=00 M0=00, P1=FF M1=0F
        vecs[0] = '{p: 8'hF3, det: 2'b10, bdet: 2'b00, any: 1'b1, idx: 1'b1};
        vecs[1] = '{p: 8'h00, det: 2'b01, bdet: 2'b10, any: 1'b1, idx: 1'b0};
        vecs[2] = '{p: 8'hFF, det: 2'b10, bdet: 2'b01, any: 1'b1, idx: 1'b1};
        vecs[3] = '{p: 8'h0A, det: 2'b00, bdet: 2'b10, any: 1'b0, idx: 1'b0};
        vecs[4] = '{p: 8'hF0, det: 2'b10, bdet: 2'b00, any: 1'b1, idx: 1'b1};
        base_cfg = mk_cfg(8'h00, 8'h00, 8'hFF, 8'h0F, 1'b0, 2'b00, 1'b0);

        RST = 1'b1; RSTP = 1'b0; CEP = 1'b0; stat_clear = 1'b0;
        C_reg = '0; inter_P = '0;
        configuration_input = 1'b0; configuration_enable = 1'b0;
        #1;
        // cleared config: both channels pattern 0 / mask 0, so inter_P=0 matches both
        chk("rst_det",    PATTERNDETECT, 2'b11);
        chk("rst_bdet",   PATTERNBDETECT, 2'b00);
        chk("rst_past",   {PATTERNDETECTPAST, PATTERNBDETECTPAST}, 4'b0);
        chk("rst_hits",   HIT_COUNT, 16'h0);
        chk("rst_sticky", {OVF_STICKY, UNF_STICKY}, 2'b00);
        chk("rst_cfgout", configuration_output, 1'b0);
        chk("rst_index",  {MATCH_ANY, MATCH_INDEX}, 2'b10);
        #13;
        RST = 1'b0;
        step();

        load_cfg(base_cfg);
        for (int i = 0; i < 5; i++) begin
            inter_P = vecs[i].p;
            #1;
            chk($sformatf("vec%0d_det", i),  PATTERNDETECT,  vecs[i].det);
            chk($sformatf("vec%0d_bdet", i), PATTERNBDETECT, vecs[i].bdet);
            chk($sformatf("vec%0d_any", i),  MATCH_ANY,      vecs[i].any);
            chk($sformatf("vec%0d_idx", i),  MATCH_INDEX,    vecs[i].idx);
            step();
        end

        // registered detect path
        load_cfg(mk_cfg(8'h00, 8'h00, 8'hFF, 8'h0F, 1'b0, 2'b00, 1'b1));
        CEP = 1'b1; inter_P = 8'hF3;
        step();
        chk("preg_load_f3", PATTERNDETECT, 2'b10);
        inter_P = 8'h00;
        #1;
        chk("preg_before_edge", PATTERNDETECT, 2'b10);
        step();
        chk("preg_after_edge", PATTERNDETECT, 2'b01);
        CEP = 1'b0; inter_P = 8'hF3;
        step();
        chk("preg_hold_cep0", PATTERNDETECT, 2'b01);
        RSTP = 1'b1; CEP = 1'b1;
        step();
        chk("rstp_det",  {PATTERNDETECT, PATTERNBDETECT}, 4'b0);
        chk("rstp_past", {PATTERNDETECTPAST, PATTERNBDETECTPAST}, 4'b0);
        RSTP = 1'b0; CEP = 1'b0;

        // C_reg sourced pattern, mask {~C[6:0],0} = E0
        load_cfg(mk_cfg(8'h00, 8'h00, 8'hFF, 8'h0F, 1'b1, 2'b10, 1'b0));
        C_reg = 8'h0F; inter_P = 8'hEF;
        #1;
        chk("selc_det0", PATTERNDETECT[0], 1'b1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        chk("selc_past0", PATTERNDETECTPAST[0], 1'b1);
        // low 5 bits 00000 neither match nor fully invert pattern 01111
        inter_P = 8'h00;
        #1;
        chk("ovf_comb",   {Overflow, Underflow, OVF_STICKY}, 3'b100);
        step();
        chk("ovf_sticky", OVF_STICKY, 1'b1);
        inter_P = 8'h10;
        #1;
        chk("bdet0_10", PATTERNBDETECT[0], 1'b1);
        step();
        inter_P = 8'h00;
        #1;
        chk("unf_comb",   Underflow, 1'b1);
        step();
        chk("unf_sticky", {OVF_STICKY, UNF_STICKY}, 2'b11);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        chk("sticky_clear", {OVF_STICKY, UNF_STICKY}, 2'b00);

        // hit counter saturation and gating
        load_cfg(base_cfg);
        inter_P = 8'hF3; CEP = 1'b1; stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        chk("cnt_clear_wins", HIT_COUNT, 16'h0);
        repeat (5) step();
        chk("cnt_5", HIT_COUNT, 16'h0500);
        CEP = 1'b0;
        repeat (3) step();
        chk("cnt_hold_cep0", HIT_COUNT, 16'h0500);
        CEP = 1'b1;
        repeat (300) step();
        chk("cnt_sat", HIT_COUNT, 16'hFF00);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        chk("cnt_stat_clear", HIT_COUNT, 16'h0);

        // build up state, then async reset between edges
        inter_P = 8'h00;
        step();
        inter_P = 8'hF3;
        step();
        repeat (3) step();
        chk("pre_rst_state", {OVF_STICKY, HIT_COUNT}, {1'b1, 16'h0401});
        chk("pre_rst_past",  PATTERNDETECTPAST, 2'b10);
        #2;
        inter_P = 8'h00;
        RST = 1'b1;
        #1;
        chk("arst_hits",   HIT_COUNT, 16'h0);
        chk("arst_sticky", OVF_STICKY, 1'b0);
        chk("arst_past",   {PATTERNDETECTPAST, PATTERNBDETECTPAST}, 4'b0);
        chk("arst_cfg",    PATTERNDETECT, 2'b11);
        step();
        chk("arst_held", HIT_COUNT, 16'h0);
        RST = 1'b0; CEP = 1'b0;
        step();

        // config chain pass-through with a mid-load pause
        for (int j = 0; j < 2*L; j++)
            bits[j] = (j < L) ? ((j % 2) == 0) : ((j % 3) == 0);
        for (int j = 0; j < 2*L; j++) begin
            configuration_enable = 1'b1;
            configuration_input  = bits[j];
            step();
            chk($sformatf("chain_%0d", j), configuration_output,
                (j + 1 >= L) ? bits[j + 1 - L] : 1'b0);
            if (j + 1 == L + 5) begin
                configuration_enable = 1'b0;
                configuration_input  = 1'b1;
                repeat (3) step();
                chk("chain_pause", configuration_output, bits[5]);
            end
        end
        configuration_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
